// File: rtl/bv_lookup_sched.sv
// Collects one partial bit vector per lookup channel, issues the aligned set to the AND stage,
// then priority-encodes the AND result into a rule index. Optional stats: `define BV_SCHED_STATS_EN.
module bv_lookup_sched #(
    parameter int BV_W        = 36,
    parameter int N_CH        = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int IDX_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      bv_valid,
    input  logic [N_CH*BV_W-1:0] bv_data,
    output logic [N_CH-1:0]      bv_ready,
    output logic                 and_valid,
    output logic [N_CH*BV_W-1:0] and_bv,
    input  logic                 and_out_valid,
    input  logic [BV_W-1:0]      and_out,
    output logic                 match_valid,
    output logic                 match_hit,
    output logic [IDX_W-1:0]     match_idx,
    output logic                 timeout_err
`ifdef BV_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_hit,
    output logic [31:0]          stat_timeout
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   loaded_q, loaded_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BV_W-1:0]   hold_q [N_CH];
    logic [BV_W-1:0]   hold_d [N_CH];
    logic              match_valid_q, match_valid_d;
    logic              match_hit_q, match_hit_d;
    logic [IDX_W-1:0]  match_idx_q, match_idx_d;
    logic              timeout_err_q, timeout_err_d;

    logic [N_CH-1:0]   accept;
    logic              all_in;

    // Bit 0 is the highest-priority rule; an all-zero vector encodes to 0.
    function automatic logic [IDX_W-1:0] lsb_idx(input logic [BV_W-1:0] v);
        lsb_idx = '0;
        for (int i = BV_W - 1; i >= 0; i--) begin
            if (v[i]) lsb_idx = IDX_W'(i);
        end
    endfunction

    assign bv_ready = (state_q == S_IDLE || state_q == S_COLLECT) ? ~loaded_q : '0;
    assign accept   = bv_valid & bv_ready;
    assign all_in   = &(loaded_q | accept);

    assign and_valid   = (state_q == S_ISSUE);
    assign match_valid = match_valid_q;
    assign match_hit   = match_hit_q;
    assign match_idx   = match_idx_q;
    assign timeout_err = timeout_err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_and_bv
        assign and_bv[BV_W*g +: BV_W] = hold_q[g];
    end

    always_comb begin
        state_d       = state_q;
        loaded_d      = loaded_q | accept;
        cnt_d         = cnt_q;
        match_valid_d = 1'b0;
        match_hit_d   = match_hit_q;
        match_idx_d   = match_idx_q;
        timeout_err_d = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            hold_d[i] = accept[i] ? bv_data[BV_W*i +: BV_W] : hold_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (all_in) begin
                    state_d = S_ISSUE;
                end else if (|accept) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                cnt_d = cnt_q + 1'b1;
                // A set completing on the timeout edge still issues.
                if (all_in) begin
                    state_d = S_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    loaded_d      = '0;
                    state_d       = S_IDLE;
                end
            end
            S_ISSUE: begin
                loaded_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (and_out_valid) begin
                    match_valid_d = 1'b1;
                    match_hit_d   = |and_out;
                    match_idx_d   = lsb_idx(and_out);
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            loaded_q      <= '0;
            cnt_q         <= '0;
            match_valid_q <= 1'b0;
            match_hit_q   <= 1'b0;
            match_idx_q   <= '0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            loaded_q      <= loaded_d;
            cnt_q         <= cnt_d;
            match_valid_q <= match_valid_d;
            match_hit_q   <= match_hit_d;
            match_idx_q   <= match_idx_d;
            timeout_err_q <= timeout_err_d;
            for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
        end
    end

`ifdef BV_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_timeout_q, stat_timeout_d;

    always_comb begin
        stat_issued_d  = stat_issued_q + {31'd0, (state_q == S_ISSUE)};
        stat_hit_d     = stat_hit_q + {31'd0, (match_valid_q && match_hit_q)};
        stat_timeout_d = stat_timeout_q + {31'd0, timeout_err_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued_q  <= '0;
            stat_hit_q     <= '0;
            stat_timeout_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_hit_q     <= stat_hit_d;
            stat_timeout_q <= stat_timeout_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_hit     = stat_hit_q;
    assign stat_timeout = stat_timeout_q;
`endif

endmodule
